cache_refill_ctrl: RTL and testbench

CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

---
 rtl/cache_refill_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_cache_refill_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - cache miss refill controller (victim writeback, line refill, tag install)
//
// Purpose:
//   Accepts one cache miss at a time, reads the victim chosen by the LRU
//   block, optionally writes a dirty victim back, fetches the missing line
//   beat by beat into the data RAM, installs the tag and notifies the LRU.
//
// Configuration macro:
//   CACHE_WRITEBACK_EN - when defined, dirty victims are written back before
//                        the refill; when undefined the writeback states do
//                        not exist and wr_req/wr_addr are tied low.
//
// Ports:
//   clk, resetn                          clock, synchronous active-low reset
//   miss_valid/miss_ready                miss handshake (ready only in IDLE)
//   miss_index, miss_tag                 set and tag of the missing line
//   lru_way / lru_index                  replacement way for the driven set
//   lru_use, lru_use_way                 one-cycle LRU update at install
//   vict_rd / vict_tag, vict_dirty       victim read, data valid next cycle
//   wr_req, wr_addr, wr_ready, wr_done   victim writeback channel
//   rd_req, rd_addr, rd_ready            refill request channel
//   ret_valid, ret_last, ret_data        refill return beats
//   fill_we, fill_way, fill_index,
//   fill_word, fill_data, fill_tag_we    data/tag RAM write port
//   miss_done                            one-cycle pulse when line installed
module cache_refill_ctrl #(
  parameter int LOG_N      = 2,
  parameter int LOG_H      = 8,
  parameter int TAG_W      = 20,
  parameter int LINE_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          miss_valid,
  output logic                          miss_ready,
  input  logic [LOG_H-1:0]              miss_index,
  input  logic [TAG_W-1:0]              miss_tag,
  input  logic [LOG_N-1:0]              lru_way,
  output logic [LOG_H-1:0]              lru_index,
  output logic                          lru_use,
  output logic [LOG_N-1:0]              lru_use_way,
  output logic                          vict_rd,
  input  logic [TAG_W-1:0]              vict_tag,
  input  logic                          vict_dirty,
  output logic                          wr_req,
  output logic [31:0]                   wr_addr,
  input  logic                          wr_ready,
  input  logic                          wr_done,
  output logic                          rd_req,
  output logic [31:0]                   rd_addr,
  input  logic                          rd_ready,
  input  logic                          ret_valid,
  input  logic                          ret_last,
  input  logic [31:0]                   ret_data,
  output logic                          fill_we,
  output logic [LOG_N-1:0]              fill_way,
  output logic [LOG_H-1:0]              fill_index,
  output logic [$clog2(LINE_WORDS)-1:0] fill_word,
  output logic [31:0]                   fill_data,
  output logic                          fill_tag_we,
  output logic                          miss_done
);

  localparam int WORD_W = $clog2(LINE_WORDS);
  // Byte-offset bits below the index in a 32-bit line address.
  localparam int OFF_W  = 32 - TAG_W - LOG_H;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOOKUP  = 3'd1,
`ifdef CACHE_WRITEBACK_EN
    WB_REQ  = 3'd2,
    WB_WAIT = 3'd3,
`endif
    RD_REQ  = 3'd4,
    RD_RECV = 3'd5,
    FINISH  = 3'd6
  } state_t;

  state_t state, state_nxt;

  logic [LOG_H-1:0]  lat_index;
  logic [TAG_W-1:0]  lat_tag;
  logic [LOG_N-1:0]  lat_way;
  logic [WORD_W-1:0] word_cnt;

  logic accept;
  assign accept = (state == IDLE) && miss_valid;

`ifdef CACHE_WRITEBACK_EN
  logic [TAG_W-1:0] lat_vict_tag;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lat_vict_tag <= '0;
    end else if (state == LOOKUP) begin
      lat_vict_tag <= vict_tag;
    end
  end
`else
  // Victim data and the writeback channel have no consumer in this build.
  logic unused_wb;
  assign unused_wb = ^{vict_tag, vict_dirty, wr_ready, wr_done};
`endif

  // Miss context is captured once at accept and held until the next accept,
  // so LRU changes during the refill cannot redirect the fill.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      lat_index <= '0;
      lat_tag   <= '0;
      lat_way   <= '0;
    end else if (accept) begin
      lat_index <= miss_index;
      lat_tag   <= miss_tag;
      lat_way   <= lru_way;
    end
  end

  // Beat counter: cleared when the refill is accepted, wraps on overlong bursts.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      word_cnt <= '0;
    end else if (state == RD_REQ && rd_ready) begin
      word_cnt <= '0;
    end else if (state == RD_RECV && ret_valid) begin
      if (word_cnt == WORD_W'(LINE_WORDS - 1)) begin
        word_cnt <= '0;
      end else begin
        word_cnt <= word_cnt + WORD_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (miss_valid) state_nxt = LOOKUP;
`ifdef CACHE_WRITEBACK_EN
      LOOKUP:  state_nxt = vict_dirty ? WB_REQ : RD_REQ;
      WB_REQ:  if (wr_ready) state_nxt = WB_WAIT;
      WB_WAIT: if (wr_done) state_nxt = RD_REQ;
`else
      LOOKUP:  state_nxt = RD_REQ;
`endif
      RD_REQ:  if (rd_ready) state_nxt = RD_RECV;
      RD_RECV: if (ret_valid && ret_last) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs from state; vict_rd and the fill strobes/data follow inputs.
  always_comb begin
    miss_ready  = 1'b0;
    lru_index   = lat_index;
    lru_use     = 1'b0;
    lru_use_way = lat_way;
    vict_rd     = 1'b0;
    wr_req      = 1'b0;
    wr_addr     = '0;
    rd_req      = 1'b0;
    rd_addr     = '0;
    fill_we     = 1'b0;
    fill_way    = lat_way;
    fill_index  = lat_index;
    fill_word   = word_cnt;
    fill_data   = '0;
    fill_tag_we = 1'b0;
    miss_done   = 1'b0;
    case (state)
      IDLE: begin
        miss_ready = 1'b1;
        lru_index  = miss_index;
        vict_rd    = miss_valid;
      end
`ifdef CACHE_WRITEBACK_EN
      WB_REQ: begin
        wr_req  = 1'b1;
        wr_addr = {lat_vict_tag, lat_index, {OFF_W{1'b0}}};
      end
`endif
      RD_REQ: begin
        rd_req  = 1'b1;
        rd_addr = {lat_tag, lat_index, {OFF_W{1'b0}}};
      end
      RD_RECV: begin
        fill_we     = ret_valid;
        fill_data   = ret_valid ? ret_data : 32'd0;
        fill_tag_we = ret_valid && ret_last;
      end
      FINISH: begin
        lru_use   = 1'b1;
        miss_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb/tb_cache_refill_ctrl.sv - self-checking bench for cache_refill_ctrl
`timescale 1ns/1ps
module tb_cache_refill_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        miss_valid, miss_ready;
  logic [7:0]  miss_index;
  logic [19:0] miss_tag;
  logic [1:0]  lru_way;
  logic [7:0]  lru_index;
  logic        lru_use;
  logic [1:0]  lru_use_way;
  logic        vict_rd;
  logic [19:0] vict_tag;
  logic        vict_dirty;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic        wr_ready, wr_done;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_ready;
  logic        ret_valid, ret_last;
  logic [31:0] ret_data;
  logic        fill_we;
  logic [1:0]  fill_way;
  logic [7:0]  fill_index;
  logic [1:0]  fill_word;
  logic [31:0] fill_data;
  logic        fill_tag_we;
  logic        miss_done;

  cache_refill_ctrl #(.LOG_N(2), .LOG_H(8), .TAG_W(20), .LINE_WORDS(4)) dut (
    .clk(clk), .resetn(resetn),
    .miss_valid(miss_valid), .miss_ready(miss_ready),
    .miss_index(miss_index), .miss_tag(miss_tag),
    .lru_way(lru_way), .lru_index(lru_index),
    .lru_use(lru_use), .lru_use_way(lru_use_way),
    .vict_rd(vict_rd), .vict_tag(vict_tag), .vict_dirty(vict_dirty),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_ready(wr_ready), .wr_done(wr_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .fill_we(fill_we), .fill_way(fill_way), .fill_index(fill_index),
    .fill_word(fill_word), .fill_data(fill_data), .fill_tag_we(fill_tag_we),
    .miss_done(miss_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  // Expected outputs for the current cycle, set by the transaction driver.
  logic        exp_miss_ready, exp_vict_rd, exp_wr_req, exp_rd_req;
  logic        exp_fill_we, exp_fill_tag_we, exp_lru_use, exp_miss_done;
  logic [31:0] exp_wr_addr, exp_rd_addr, exp_fill_data;
  logic [7:0]  exp_lru_index, exp_fill_index;
  logic [1:0]  exp_lru_use_way, exp_fill_way, exp_fill_word;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check("miss_ready", miss_ready, exp_miss_ready);
      check("vict_rd", vict_rd, exp_vict_rd);
      check("wr_req", wr_req, exp_wr_req);
      check("rd_req", rd_req, exp_rd_req);
      check("fill_we", fill_we, exp_fill_we);
      check("fill_tag_we", fill_tag_we, exp_fill_tag_we);
      check("lru_use", lru_use, exp_lru_use);
      check("miss_done", miss_done, exp_miss_done);
`ifdef CACHE_WRITEBACK_EN
      if (exp_wr_req) check("wr_addr", wr_addr, exp_wr_addr);
`else
      check("wr_addr", wr_addr, 32'd0);
`endif
      if (exp_rd_req) check("rd_addr", rd_addr, exp_rd_addr);
      if (exp_vict_rd || exp_lru_use) check("lru_index", lru_index, exp_lru_index);
      if (exp_lru_use) check("lru_use_way", lru_use_way, exp_lru_use_way);
      if (exp_fill_we) begin
        check("fill_way", fill_way, exp_fill_way);
        check("fill_index", fill_index, exp_fill_index);
        check("fill_word", fill_word, exp_fill_word);
        check("fill_data", fill_data, exp_fill_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Randomise every input the controller must ignore in the coming cycle and
  // clear the expectations; callers then set what the cycle is about.
  task automatic noise();
    miss_valid = 1'($urandom);
    miss_index = 8'($urandom);
    miss_tag   = 20'($urandom);
    lru_way    = 2'($urandom);
    vict_tag   = 20'($urandom);
    vict_dirty = 1'($urandom);
`ifdef CACHE_WRITEBACK_EN
    wr_ready   = 1'b0;
    wr_done    = 1'b0;
`else
    wr_ready   = 1'($urandom);
    wr_done    = 1'($urandom);
`endif
    rd_ready   = 1'b0;
    ret_valid  = 1'b0;
    ret_last   = 1'b0;
    ret_data   = $urandom;
    exp_miss_ready = 1'b0; exp_vict_rd = 1'b0; exp_wr_req = 1'b0; exp_rd_req = 1'b0;
    exp_fill_we = 1'b0; exp_fill_tag_we = 1'b0; exp_lru_use = 1'b0; exp_miss_done = 1'b0;
    exp_wr_addr = '0; exp_rd_addr = '0; exp_fill_data = '0;
    exp_lru_index = '0; exp_fill_index = '0;
    exp_lru_use_way = '0; exp_fill_way = '0; exp_fill_word = '0;
  endtask

  // One complete miss as seen from the pipeline and bus. gap<0 means random
  // 0..2 idle cycles before each beat; rst_at>=0 resets before that beat.
  task automatic do_miss(input logic [7:0] idx, input logic [19:0] tag, input logic [1:0] way,
                         input logic [19:0] vt, input logic dirty,
                         input int wr_wait, input int done_wait, input int rd_wait,
                         input int nbeats, input int gap, input int rst_at, input bit pin);
    int g;
    logic [31:0] d;
    for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
      noise(); miss_valid = 1'b0; exp_miss_ready = 1'b1; tick();
    end
    noise();
    miss_valid = 1'b1; miss_index = idx; miss_tag = tag; lru_way = way;
    exp_miss_ready = 1'b1; exp_vict_rd = 1'b1; exp_lru_index = idx;
    tick();
    noise(); vict_tag = vt; vict_dirty = dirty; tick();
`ifdef CACHE_WRITEBACK_EN
    if (dirty) begin
      for (int i = 0; i <= wr_wait; i++) begin
        noise();
        wr_ready = (i == wr_wait);
        exp_wr_req = 1'b1; exp_wr_addr = {vt, idx, 4'h0};
        if (pin) begin
          @(negedge clk); check("lit_wr_addr", wr_addr, 32'h11111050);
        end
        tick();
      end
      for (int i = 0; i <= done_wait; i++) begin
        noise(); wr_done = (i == done_wait); tick();
      end
    end
`endif
    for (int i = 0; i <= rd_wait; i++) begin
      noise();
      rd_ready = (i == rd_wait);
      exp_rd_req = 1'b1; exp_rd_addr = {tag, idx, 4'h0};
      if (pin && !dirty) begin
        @(negedge clk); check("lit_rd_addr", rd_addr, 32'hABCDE120);
      end
      tick();
    end
    for (int b = 0; b < nbeats; b++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      for (int i = 0; i < g; i++) begin
        noise(); tick();
      end
      if (b == rst_at) begin
        noise(); resetn = 1'b0; tick(); resetn = 1'b1;
        return;
      end
      noise();
      d = $urandom;
      ret_valid = 1'b1; ret_last = (b == nbeats - 1); ret_data = d;
      exp_fill_we = 1'b1; exp_fill_tag_we = (b == nbeats - 1);
      exp_fill_way = way; exp_fill_index = idx; exp_fill_word = 2'(b % 4); exp_fill_data = d;
      if (pin && !dirty) begin
        @(negedge clk); check("lit_fill_way", fill_way, 32'd2);
      end
      tick();
    end
    noise();
    exp_lru_use = 1'b1; exp_lru_use_way = way; exp_lru_index = idx; exp_miss_done = 1'b1;
    if (pin && !dirty) begin
      @(negedge clk); check("lit_lru_use_way", lru_use_way, 32'd2);
    end
    tick();
  endtask

  initial begin
    int nb;
    noise();
    miss_valid = 1'b0;
    resetn = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    noise(); miss_valid = 1'b0; exp_miss_ready = 1'b1;
    check_en = 1'b1;
    @(negedge clk);
    check("rst_miss_ready", miss_ready, 32'd1);
    check("rst_rd_addr", rd_addr, 32'd0);
    check("rst_wr_addr", wr_addr, 32'd0);
    tick();
    resetn = 1'b1;

    // Clean miss, zero-wait bus, pinned literal address/way.
    do_miss(8'h12, 20'hABCDE, 2'd2, 20'h0, 1'b0, 0, 0, 0, 4, 0, -1, 1'b1);
    // Dirty victim (written back only when the feature is built in).
    do_miss(8'h05, 20'h22222, 2'd1, 20'h11111, 1'b1, 0, 2, 0, 4, 0, -1, 1'b1);
    // Slow writeback accept and slow refill accept.
    do_miss(8'h33, 20'h45678, 2'd3, 20'h0F0F0, 1'b1, 5, 1, 3, 4, 0, -1, 1'b0);
    // Two idle cycles between every beat.
    do_miss(8'h7E, 20'h13579, 2'd0, 20'h0, 1'b0, 0, 0, 0, 4, 2, -1, 1'b0);
    // Reset after beat 2, then a normal miss.
    do_miss(8'hA0, 20'hFEDCB, 2'd1, 20'h0, 1'b0, 0, 0, 1, 4, 0, 2, 1'b0);
    do_miss(8'hA1, 20'h00F00, 2'd2, 20'h0, 1'b0, 0, 0, 0, 4, 1, -1, 1'b0);
    // Randomised misses, including short/long bursts and occasional resets.
    for (int n = 0; n < 60; n++) begin
      nb = int'($urandom_range(1, 6));
      do_miss(8'($urandom), 20'($urandom), 2'($urandom), 20'($urandom), 1'($urandom),
              int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
              nb, -1, (($urandom_range(0, 7) == 0) && nb > 2) ? 2 : -1, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      noise(); miss_valid = 1'b0; exp_miss_ready = 1'b1; tick();
    end
    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
